uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Shares one `channel_uart_transmitter` between two requesters. Round-robin arbitration latches one 16-bit word per grant and pulses the transmitter's `transfer_data` input. The block then tracks the transmitter's busy flag until the frame completes. It also owns the transmitter's `baud_select` setting and applies configuration changes only between frames. It sits between the host-side producers and the transmitter; the receiver path is untouched.

## Interface
- `DATA_W`, 16, word width per transfer
- `BAUD_RESET`, 3'd5, `tx_baud_select` value after reset
- `START_TIMEOUT`, 64, cycles to wait for `tx_busy` to rise after a transfer pulse
- `clk` in 1: single clock, all logic rising-edge
- `reset` in 1: synchronous, active-low
- `req0`, `req1` in 1 each: request; held high with data stable until matching ack
- `data0`, `data1` in DATA_W each: word offered by requester 0/1
- `ack0`, `ack1` out 1 each: one-cycle pulse, word latched
- `cfg_we` in 1: baud write strobe
- `cfg_baud` in 3: new baud code
- `tx_busy` in 1: transmitter frame in progress
- `tx_data` out DATA_W: to transmitter `data`
- `tx_transfer` out 1: to transmitter `transfer_data`, one-cycle pulse
- `tx_baud_select` out 3: to transmitter `baud_select`
- `done` out 1: one-cycle pulse, frame finished
- `err_timeout` out 1: one-cycle pulse, transmitter never went busy
- `idle` out 1: high in IDLE

## Operation
- All outputs registered. Reset values:
  - `ack*`, `tx_transfer`, `done`, `err_timeout` = 0
  - `tx_data` = 0
  - `tx_baud_select` = BAUD_RESET
  - `idle` = 1
- Reset also sets state IDLE, round-robin pointer to favour requester 0, pending-config flag cleared.
- States: IDLE, SEND, WAIT_START, WAIT_DONE.
- IDLE, pending config or `cfg_we` this edge:
  - Load `tx_baud_select` (`cfg_baud` if `cfg_we`, else the pending value).
  - Clear pending. No grant on this edge.
- IDLE, else, any req high:
  - Grant the pointer's favoured requester if requesting, else the other.
  - Load `tx_data`; assert `ack_k` and `tx_transfer`.
  - Point pointer at the non-granted requester. Go to SEND.
- SEND: deassert `ack_k` and `tx_transfer`. Load counter = START_TIMEOUT−1. Go to WAIT_START.
- WAIT_START:
  - `tx_busy` high → WAIT_DONE.
  - Else counter 0 → `err_timeout` pulse, go to IDLE.
  - Else decrement the counter.
- WAIT_DONE: `tx_busy` low → `done` pulse, go to IDLE.
- `cfg_we` outside IDLE: latch `cfg_baud` into pending; a later write overwrites an earlier one. `tx_baud_select` never changes outside IDLE.
- A requester dropping req before ack is legal; the arbiter samples only at IDLE edges.
- Reset mid-frame returns all state and outputs to reset values on that edge. The transmitter is reset by the same `reset`.

## Timing
- Req high before edge N in IDLE, no config pending: `ack`, `tx_transfer`, `tx_data` valid after edge N. `tx_data` holds until the next grant.
- Pulses clear after edge N+1. The counter starts at edge N+1.
- `tx_busy` sampled high at edge N+1+k (k < START_TIMEOUT) → WAIT_DONE.
- `tx_busy` sampled low in WAIT_DONE at edge M → `done` pulse and IDLE after M. The earliest next grant is at edge M+1.
- Both requesting continuously: grants alternate 0,1,0,1.
- Config write and req on the same IDLE edge: baud applied first, grant one edge later.
- Timeout: no busy through START_TIMEOUT WAIT_START cycles → `err_timeout` on the edge after the counter reads 0.

## Structure
- Shared package `uart_pkg`:
  - State enum (`ARB_IDLE`, `ARB_SEND`, `ARB_WAIT_START`, `ARB_WAIT_DONE`)
  - `DATA_W` default
  - Baud code constants, including the reset code 5
- One sub-module `uart_rr_pick`: combinational 2-way pick from req0/req1 and the pointer, returning valid and index. FSM, counter, config and pending logic stay in the top.

## Test plan
- **Single request:** reset low 5 cycles then high; req0 with data0=16'h3333. Required:
  - One ack0 and one `tx_transfer` pulse, `tx_data`=16'h3333.
  - `done` after the transmitter drops busy.
  - Loopback receiver data = 16'h3333.
- **Contention:** req0 and req1 held high with data0=16'h0005, data1=16'hA5A5. Required:
  - Grant order 0,1,0,1.
  - Each ack exactly once per frame; no `tx_transfer` while `tx_busy`=1.
- **Config mid-frame:** `cfg_we`, `cfg_baud`=3 during WAIT_DONE. Required:
  - `tx_baud_select` stays 5 until the edge after `done`, then becomes 3.
  - The next grant follows one edge later.
- **Timeout:** `tx_busy` forced 0, START_TIMEOUT=8. Required:
  - `err_timeout` pulse 8 cycles after SEND; `idle`=1; no `done`.
- **Reset mid-frame:** reset low in WAIT_DONE. Required:
  - Next edge: `idle`=1, all pulses 0, `tx_baud_select`=5, pending config discarded.
  - Pointer favours requester 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter.
//   - arb_state_e : arbiter FSM states
//   - DATA_W_DEFAULT : default word width per transfer
//   - baud code constants, including the post-reset code
//   - rr_other() : round-robin helper returning the non-granted requester
package uart_pkg;

  localparam int unsigned DATA_W_DEFAULT = 16;

  localparam int unsigned BAUD_W = 3;
  localparam logic [BAUD_W-1:0] BAUD_CODE_MIN   = 3'd0;
  localparam logic [BAUD_W-1:0] BAUD_CODE_MAX   = 3'd7;
  localparam logic [BAUD_W-1:0] BAUD_RESET_CODE = 3'd5;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_SEND,
    ARB_WAIT_START,
    ARB_WAIT_DONE
  } arb_state_e;

  // After granting requester idx, the other one is favoured next.
  function automatic logic rr_other(input logic idx);
    return ~idx;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Host-side bundle for the UART transmit arbiter.
//   req0/req1   : requests, held with data stable until the matching ack
//   data0/data1 : offered words
//   ack0/ack1   : one-cycle acknowledge, word latched
//   cfg_we      : baud write strobe
//   cfg_baud    : new baud code
// modport master : producers (drive requests and config)
// modport slave  : arbiter (drives acks)
interface uart_tx_arbiter_if #(
  parameter int unsigned DATA_W = uart_pkg::DATA_W_DEFAULT
) ();
  import uart_pkg::*;

  logic              req0;
  logic              req1;
  logic [DATA_W-1:0] data0;
  logic [DATA_W-1:0] data1;
  logic              ack0;
  logic              ack1;
  logic              cfg_we;
  logic [BAUD_W-1:0] cfg_baud;

  modport master (
    output req0, req1, data0, data1, cfg_we, cfg_baud,
    input  ack0, ack1
  );

  modport slave (
    input  req0, req1, data0, data1, cfg_we, cfg_baud,
    output ack0, ack1
  );

endinterface

// File: rtl/uart_rr_pick.sv
// Combinational two-way round-robin pick.
//   req0_i/req1_i : requests
//   ptr_i         : favoured requester (0 or 1)
//   valid_o       : some requester is asking
//   idx_o         : chosen requester; the favoured one if asking, else the other
module uart_rr_pick (
  input  logic req0_i,
  input  logic req1_i,
  input  logic ptr_i,
  output logic valid_o,
  output logic idx_o
);

  always_comb begin
    valid_o = req0_i | req1_i;
    if (ptr_i) begin
      idx_o = req1_i ? 1'b1 : 1'b0;
    end else begin
      idx_o = req0_i ? 1'b0 : 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between two requesters.
//   clk, reset     : rising-edge clock, synchronous active-low reset
//   host           : request/ack/config bundle (slave side)
//   tx_busy        : transmitter frame in progress
//   tx_data        : word to the transmitter, held until the next grant
//   tx_transfer    : one-cycle start pulse to the transmitter
//   tx_baud_select : baud code, changed only while idle
//   done           : one-cycle pulse, frame finished
//   err_timeout    : one-cycle pulse, transmitter never went busy
//   idle           : high while the arbiter is idle
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned       DATA_W        = DATA_W_DEFAULT,
  parameter logic [BAUD_W-1:0] BAUD_RESET    = BAUD_RESET_CODE,
  parameter int unsigned       START_TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                reset,
  uart_tx_arbiter_if.slave    host,
  input  logic                tx_busy,
  output logic [DATA_W-1:0]   tx_data,
  output logic                tx_transfer,
  output logic [BAUD_W-1:0]   tx_baud_select,
  output logic                done,
  output logic                err_timeout,
  output logic                idle
);

  localparam int unsigned CntW = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(START_TIMEOUT - 1);

  arb_state_e        state_q;
  logic              ptr_q;
  logic              pend_q;
  logic [BAUD_W-1:0] pend_baud_q;
  logic [CntW-1:0]   cnt_q;
  logic              ack0_q;
  logic              ack1_q;
  logic              tx_transfer_q;
  logic [DATA_W-1:0] tx_data_q;
  logic [BAUD_W-1:0] baud_q;
  logic              done_q;
  logic              err_q;
  logic              idle_q;

  logic              pick_valid;
  logic              pick_idx;
  logic [DATA_W-1:0] pick_data;

  uart_rr_pick u_pick (
    .req0_i  (host.req0),
    .req1_i  (host.req1),
    .ptr_i   (ptr_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  always_comb begin
    pick_data = pick_idx ? host.data1 : host.data0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ARB_IDLE;
      ptr_q         <= 1'b0;
      pend_q        <= 1'b0;
      pend_baud_q   <= BAUD_RESET;
      cnt_q         <= '0;
      ack0_q        <= 1'b0;
      ack1_q        <= 1'b0;
      tx_transfer_q <= 1'b0;
      tx_data_q     <= '0;
      baud_q        <= BAUD_RESET;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      idle_q        <= 1'b1;
    end else begin
      ack0_q        <= 1'b0;
      ack1_q        <= 1'b0;
      tx_transfer_q <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;

      // Writes during a frame are parked; the latest one wins.
      if (host.cfg_we && (state_q != ARB_IDLE)) begin
        pend_q      <= 1'b1;
        pend_baud_q <= host.cfg_baud;
      end

      case (state_q)
        ARB_IDLE: begin
          // Config takes the whole edge so baud is stable before the next frame.
          if (pend_q || host.cfg_we) begin
            baud_q <= host.cfg_we ? host.cfg_baud : pend_baud_q;
            pend_q <= 1'b0;
          end else if (pick_valid) begin
            tx_data_q     <= pick_data;
            ack0_q        <= ~pick_idx;
            ack1_q        <= pick_idx;
            tx_transfer_q <= 1'b1;
            ptr_q         <= rr_other(pick_idx);
            idle_q        <= 1'b0;
            state_q       <= ARB_SEND;
          end
        end
        ARB_SEND: begin
          cnt_q   <= CntLoad;
          state_q <= ARB_WAIT_START;
        end
        ARB_WAIT_START: begin
          if (tx_busy) begin
            state_q <= ARB_WAIT_DONE;
          end else if (cnt_q == '0) begin
            err_q   <= 1'b1;
            idle_q  <= 1'b1;
            state_q <= ARB_IDLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ARB_WAIT_DONE: begin
          if (!tx_busy) begin
            done_q  <= 1'b1;
            idle_q  <= 1'b1;
            state_q <= ARB_IDLE;
          end
        end
        default: begin
          idle_q  <= 1'b1;
          state_q <= ARB_IDLE;
        end
      endcase
    end
  end

  assign host.ack0      = ack0_q;
  assign host.ack1      = ack1_q;
  assign tx_data        = tx_data_q;
  assign tx_transfer    = tx_transfer_q;
  assign tx_baud_select = baud_q;
  assign done           = done_q;
  assign err_timeout    = err_q;
  assign idle           = idle_q;

endmodule
